// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin owner of the shared register-file
// write port; every output toward the file is registered.
module rf_write_arbiter #(
  parameter int NREQ = 4,
  parameter int DW   = 8,
  parameter int AW   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [DW-1:0]      X,
  output logic [AW-1:0]      XADDR,
  output logic               write,
  output logic               conflict
);

  localparam int PW = 2;

  logic [PW-1:0]   ptr;
  logic [PW-1:0]   ptr_nxt;
  logic [PW-1:0]   win;
  logic            found;
  logic            coll;
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] win_oh;
  logic [DW-1:0]   win_data;
  logic [AW-1:0]   win_addr;

  // a grant still visible masks its owner for one cycle
  assign elig = req & ~gnt;

  // two-pass search: indices >= ptr first, then wrap to the bottom
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && elig[i] && (PW'(i) >= ptr)) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!found && elig[i]) begin
        found = 1'b1;
        win   = PW'(i);
      end
    end
  end

  assign ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + PW'(1);

  always_comb begin
    win_oh   = '0;
    win_data = '0;
    win_addr = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (PW'(i) == win) begin
        win_oh[i] = 1'b1;
        win_data  = req_data[i*DW +: DW];
        win_addr  = req_addr[i*AW +: AW];
      end
    end
  end

  always_comb begin
    coll = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = i + 1; j < NREQ; j++) begin
        if (elig[i] && elig[j] &&
            (req_addr[i*AW +: AW] == req_addr[j*AW +: AW]))
          coll = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt      <= '0;
      X        <= '0;
      XADDR    <= '0;
      write    <= 1'b0;
      conflict <= 1'b0;
      ptr      <= '0;
    end else begin
      conflict <= coll & ~hold;
      if (!hold && found) begin
        gnt   <= win_oh;
        write <= 1'b1;
        X     <= win_data;
        XADDR <= win_addr;
        ptr   <= ptr_nxt;
      end else begin
        gnt   <= '0;
        write <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed plus random stimulus, expected
// responses queued by a reference model and popped by a monitor.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        hold;
  logic [3:0]  req;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  X;
  logic [1:0]  XADDR;
  logic        write;
  logic        conflict;

  rf_write_arbiter #(.NREQ(4), .DW(8), .AW(2)) dut (
    .clk(clk), .rst(rst), .hold(hold),
    .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .X(X), .XADDR(XADDR),
    .write(write), .conflict(conflict)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic       wr;
    logic [7:0] x;
    logic [1:0] xa;
    logic       cf;
  } exp_t;

  exp_t       q[$];
  exp_t       me;
  int         n_chk;
  int         n_fail;
  bit         mon_en;
  int         m_ptr;
  logic [3:0] m_gnt;
  logic [7:0] m_x;
  logic [1:0] m_xa;
  logic [7:0] rf_obs [4];

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  // winner = eligible requester at smallest rotational distance from ptr
  task automatic predict();
    exp_t       e;
    int         best;
    int         bestd;
    int         d;
    int         cnt [4];
    logic [3:0] el;
    el    = req & ~m_gnt;
    e.gnt = '0;
    e.wr  = 1'b0;
    e.x   = m_x;
    e.xa  = m_xa;
    e.cf  = 1'b0;
    if (!hold) begin
      cnt   = '{default: 0};
      best  = -1;
      bestd = 99;
      for (int i = 0; i < 4; i++) begin
        if (el[i]) begin
          cnt[req_addr[i*2 +: 2]]++;
          d = (i - m_ptr + 4) % 4;
          if (d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
      end
      for (int a = 0; a < 4; a++)
        if (cnt[a] >= 2) e.cf = 1'b1;
      if (best >= 0) begin
        e.gnt = 4'b0001 << best;
        e.wr  = 1'b1;
        e.x   = req_data[best*8 +: 8];
        e.xa  = req_addr[best*2 +: 2];
        m_ptr = (best + 1) % 4;
      end
    end
    m_gnt = e.gnt;
    m_x   = e.x;
    m_xa  = e.xa;
    q.push_back(e);
  endtask

  task automatic cyc();
    predict();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_ptr = 0;
    m_gnt = '0;
    m_x   = '0;
    m_xa  = '0;
  endtask

  always @(posedge clk) begin
    if (mon_en) begin
      #1;
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL underflow: got output with no expectation");
      end else begin
        me = q.pop_front();
        chk("gnt", 32'(gnt), 32'(me.gnt));
        chk("write", 32'(write), 32'(me.wr));
        chk("X", 32'(X), 32'(me.x));
        chk("XADDR", 32'(XADDR), 32'(me.xa));
        chk("conflict", 32'(conflict), 32'(me.cf));
        if (write === 1'b1) rf_obs[XADDR] = X;
      end
    end
  end

  initial begin
    n_chk    = 0;
    n_fail   = 0;
    mon_en   = 0;
    rst      = 1'b1;
    hold     = 1'b0;
    req      = '0;
    req_addr = '0;
    req_data = '0;
    rf_obs   = '{default: 8'h00};
    model_reset();

    #5;
    rst      = 1'b0;
    req      = 4'hf;
    req_data = {8'h13, 8'h12, 8'h11, 8'h10};
    req_addr = {2'd3, 2'd2, 2'd1, 2'd0};
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_write", 32'(write), 0);
    chk("rst_X", 32'(X), 0);
    chk("rst_XADDR", 32'(XADDR), 0);
    chk("rst_conflict", 32'(conflict), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_gnt", 32'(gnt), 0);
    chk("rst_hold_write", 32'(write), 0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b1;
    mon_en = 1;

    repeat (5) cyc();
    req = '0;
    cyc();
    cyc();
    for (int i = 0; i < 4; i++)
      chk("rr_reg", 32'(rf_obs[i]), 32'h10 + 32'(i));

    req_addr[7:6]  = 2'd2;
    req_data[31:24] = 8'h77;
    req  = 4'b1000;
    hold = 1'b1;
    repeat (3) cyc();
    hold = 1'b0;
    cyc();
    req = '0;
    cyc();
    cyc();
    chk("hold_reg2", 32'(rf_obs[2]), 32'h77);

    req_addr[1:0]  = 2'd1;
    req_addr[3:2]  = 2'd1;
    req_data[7:0]  = 8'hAA;
    req_data[15:8] = 8'h55;
    req = 4'b0011;
    cyc();
    cyc();
    req = '0;
    cyc();
    cyc();
    chk("coll_reg1", 32'(rf_obs[1]), 32'h55);

    req_addr[5:4]   = 2'd3;
    req_data[23:16] = 8'h5A;
    req = 4'b0100;
    repeat (4) cyc();
    req = '0;
    cyc();
    cyc();
    chk("single_reg3", 32'(rf_obs[3]), 32'h5A);

    req = 4'b0100;
    cyc();
    chk("mid_write", 32'(write), 1);
    chk("mid_gnt", 32'(gnt), 32'h4);
    mon_en = 0;
    rst    = 1'b0;
    #1;
    chk("mid_rst_write", 32'(write), 0);
    chk("mid_rst_gnt", 32'(gnt), 0);
    chk("mid_rst_X", 32'(X), 0);
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    mon_en = 1;
    cyc();

    for (int c = 0; c < 400; c++) begin
      hold = ($urandom_range(0, 99) < 15);
      for (int i = 0; i < 4; i++) begin
        if (m_gnt[i]) begin
          req[i] = $urandom_range(0, 1) == 1;
          req_addr[i*2 +: 2] = 2'($urandom);
          req_data[i*8 +: 8] = 8'($urandom);
        end else if (req[i]) begin
          if ($urandom_range(0, 99) < 3) req[i] = 1'b0;
        end else if ($urandom_range(0, 99) < 30) begin
          req[i] = 1'b1;
          req_addr[i*2 +: 2] = 2'($urandom);
          req_data[i*8 +: 8] = 8'($urandom);
        end
      end
      cyc();
    end
    req  = '0;
    hold = 1'b0;
    cyc();
    cyc();
    chk("queue_drained", 32'(q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
